// File: rtl/alu_req_arbiter_pkg.sv
// alu_arb_pkg: definitions shared by the ALU request arbiter and its ALU.
//   - opcode map seen by requesters and by the ALU
//   - arbiter FSM state encoding
//   - requester ID constants carried on rsp_id
package alu_arb_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_SHL = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;

endpackage

// File: rtl/alu_req_arbiter_alu.sv
// alu_req_arbiter_alu: the shared combinational ALU.
//   Opcode     in  2                opcode (alu_arb_pkg map)
//   In_a, In_b in  num_bit_of_data  operands
//   Shift_dist in  num_shift_bit    left-shift distance
//   Out_data   out num_bit_of_data  result, modulo 2^num_bit_of_data
// The reserved opcode returns 0; the arbiter masks it anyway.
module alu_req_arbiter_alu
  import alu_arb_pkg::*;
#(
  parameter int num_bit_of_data = 32,
  parameter int num_shift_bit   = 3
) (
  input  logic [1:0]                 Opcode,
  input  logic [num_bit_of_data-1:0] In_a,
  input  logic [num_bit_of_data-1:0] In_b,
  input  logic [num_shift_bit-1:0]   Shift_dist,
  output logic [num_bit_of_data-1:0] Out_data
);

  always_comb begin
    Out_data = '0;
    case (Opcode)
      OP_ADD:  Out_data = In_a + In_b;
      OP_SUB:  Out_data = In_a - In_b;
      OP_SHL:  Out_data = In_a << Shift_dist;
      default: Out_data = '0;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one ALU between two valid/ready requesters with
// round-robin arbitration and a single ID-tagged response channel.
//   clk, rst_n                    clock / async active-low reset
//   reqN_valid/ready              command handshake, N = 0,1
//   reqN_opcode/a/b/dist          command payload
//   rsp_valid/ready               response handshake
//   rsp_id/data/err               response payload (err = reserved opcode)
//   done_count                    completed responses, wraps
//
// state | meaning
// IDLE  | arbitrate; accept one command and latch its payload
// EXEC  | ALU driven from latched operands; capture result
// RESP  | hold response until rsp_ready; then update pointer and count
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int num_bit_of_data = 32,
  parameter int num_shift_bit   = 3,
  parameter int cnt_width       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [1:0]                 req0_opcode,
  input  logic [num_bit_of_data-1:0] req0_a,
  input  logic [num_bit_of_data-1:0] req0_b,
  input  logic [num_shift_bit-1:0]   req0_dist,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [1:0]                 req1_opcode,
  input  logic [num_bit_of_data-1:0] req1_a,
  input  logic [num_bit_of_data-1:0] req1_b,
  input  logic [num_shift_bit-1:0]   req1_dist,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [num_bit_of_data-1:0] rsp_data,
  output logic                       rsp_err,
  output logic [cnt_width-1:0]       done_count
);

  arb_state_e                 state_q, state_d;
  logic                       ptr_q, ptr_d;
  logic [1:0]                 op_q, op_d;
  logic [num_bit_of_data-1:0] a_q, a_d, b_q, b_d;
  logic [num_shift_bit-1:0]   dist_q, dist_d;
  logic                       id_q, id_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [num_bit_of_data-1:0] rsp_data_q, rsp_data_d;
  logic                       rsp_err_q, rsp_err_d;
  logic [cnt_width-1:0]       done_q, done_d;

  logic                       grant_vld;
  logic                       grant_id;
  logic [num_bit_of_data-1:0] alu_out;

  // The pointer only matters on contention; a lone requester always wins.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = ptr_q;
    else                          grant_id = req1_valid;
  end

  // rst_n gating keeps both readies low while reset is held.
  assign req0_ready = rst_n && (state_q == IDLE) && grant_vld && (grant_id == REQ_ID_0);
  assign req1_ready = rst_n && (state_q == IDLE) && grant_vld && (grant_id == REQ_ID_1);

  alu_req_arbiter_alu #(
    .num_bit_of_data (num_bit_of_data),
    .num_shift_bit   (num_shift_bit)
  ) u_alu (
    .Opcode     (op_q),
    .In_a       (a_q),
    .In_b       (b_q),
    .Shift_dist (dist_q),
    .Out_data   (alu_out)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    dist_d      = dist_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    done_d      = done_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d = EXEC;
          id_d    = grant_id;
          op_d    = grant_id ? req1_opcode : req0_opcode;
          a_d     = grant_id ? req1_a      : req0_a;
          b_d     = grant_id ? req1_b      : req0_b;
          dist_d  = grant_id ? req1_dist   : req0_dist;
        end
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        if (op_q == OP_RSV) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_data_d = alu_out;
          rsp_err_d  = 1'b0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          done_d      = done_q + cnt_width'(1);
          ptr_d       = ~id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      dist_q      <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dist_q      <= dist_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      done_q      <= done_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign done_count = done_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_opcode, req1_opcode;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_dist, req1_dist;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;
  logic [15:0] done_count;

  always #5 clk = ~clk;

  alu_req_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_dist(req0_dist),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_dist(req1_dist),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .done_count(done_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=0x%08h exp=0x%08h", tag, act, exp);
    end
  endtask

  // Requester command registers driven onto the ports.
  bit          v[2];
  logic [1:0]  op[2];
  logic [31:0] av[2], bv[2];
  logic [2:0]  dv[2];

  task automatic apply();
    req0_valid = v[0]; req0_opcode = op[0]; req0_a = av[0]; req0_b = bv[0]; req0_dist = dv[0];
    req1_valid = v[1]; req1_opcode = op[1]; req1_a = av[1]; req1_b = bv[1]; req1_dist = dv[1];
  endtask

  task automatic set_req(input int id, input bit vl, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b, input logic [2:0] d);
    v[id] = vl; op[id] = o; av[id] = a; bv[id] = b; dv[id] = d;
    apply();
  endtask

  // Reference: result computed as plain modular arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [2:0] d);
    longint unsigned m, r;
    m = 64'h1_0000_0000;
    case (o)
      2'd0:    r = (longint'(a) + longint'(b)) % m;
      2'd1:    r = (longint'(a) + m - longint'(b)) % m;
      2'd2:    r = (longint'(a) * (64'd1 << d)) % m;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  // Transaction-level model: one op in flight; response visible from the
  // second cycle after acceptance until the response handshake.
  bit          m_busy, m_vis, m_ptr, m_id, m_err;
  logic [31:0] m_data;
  int          m_done;
  int          acc_id;
  bit          hs;
  logic [31:0] rsp_log[$];
  int          id_log[$];

  task automatic model_reset();
    m_busy = 0; m_vis = 0; m_ptr = 0; m_id = 0; m_err = 0; m_data = 0; m_done = 0;
  endtask

  task automatic step();
    bit e0, e1;
    @(negedge clk);
    acc_id = -1; hs = 0; e0 = 0; e1 = 0;
    if (!m_busy) begin
      if (req0_valid && (!req1_valid || !m_ptr)) e0 = 1;
      else if (req1_valid) e1 = 1;
    end
    check_val("req0_ready", req0_ready, e0);
    check_val("req1_ready", req1_ready, e1);
    check_val("rsp_valid", rsp_valid, m_vis);
    check_val("done_count", done_count, m_done);
    if (m_vis) begin
      check_val("rsp_id", rsp_id, m_id);
      check_val("rsp_data", rsp_data, m_data);
      check_val("rsp_err", rsp_err, m_err);
      if (rsp_ready) begin
        hs = 1;
        rsp_log.push_back(rsp_data);
        id_log.push_back(int'(rsp_id));
        m_done = (m_done + 1) % 65536;
        m_ptr = ~m_id;
        m_busy = 0;
        m_vis = 0;
      end
    end else if (m_busy) begin
      m_vis = 1;
    end else if (e0 || e1) begin
      m_busy = 1;
      m_id = e1;
      acc_id = e1 ? 1 : 0;
      m_err = (op[acc_id] == 2'd3);
      m_data = ref_result(op[acc_id], av[acc_id], bv[acc_id], dv[acc_id]);
    end
    @(posedge clk); #1;
  endtask

  // Issue one command from requester id and run it to its response.
  task automatic run_op(input int id, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] d);
    int n;
    set_req(id, 1, o, a, b, d);
    n = 0;
    do begin step(); n++; end while (acc_id != id && n < 10);
    if (acc_id != id) check_val("accept_timeout", 0, 1);
    set_req(id, 0, o, a, b, d);
    n = 0;
    do begin step(); n++; end while (!hs && n < 10);
    if (!hs) check_val("rsp_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_busy && n < 20) begin step(); n++; end
    if (m_busy) check_val("drain_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int grants[$];
    for (int i = 0; i < 2; i++) begin v[i] = 0; op[i] = 0; av[i] = 0; bv[i] = 0; dv[i] = 0; end
    apply();
    rsp_ready = 1;
    rst_n = 0;
    model_reset();
    set_req(0, 1, 2'd0, 32'd1, 32'd1, 3'd0);   // valid during reset must not see ready
    repeat (3) @(posedge clk);
    #2;
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_id", rsp_id, 0);
    check_val("rst_rsp_data", rsp_data, 0);
    check_val("rst_rsp_err", rsp_err, 0);
    check_val("rst_done", done_count, 0);
    check_val("rst_req0_ready", req0_ready, 0);
    check_val("rst_req1_ready", req1_ready, 0);
    set_req(0, 0, 2'd0, 32'd0, 32'd0, 3'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // Single request.
    rsp_log.delete(); id_log.delete();
    run_op(0, 2'd0, 32'd25, 32'd10, 3'd0);
    check_val("single_data", rsp_log[0], 32'd35);
    check_val("single_id", id_log[0], 0);
    check_val("single_done", done_count, 1);

    // Shifts, including distance 0.
    rsp_log.delete();
    run_op(0, 2'd2, 32'd5, 32'd0, 3'd2);
    run_op(0, 2'd2, 32'd5, 32'd0, 3'd0);
    check_val("shl2", rsp_log[0], 32'd20);
    check_val("shl0", rsp_log[1], 32'd5);

    // Subtract wrap.
    rsp_log.delete(); id_log.delete();
    run_op(1, 2'd1, 32'd13, 32'd17, 3'd0);
    check_val("sub_wrap", rsp_log[0], 32'hFFFF_FFFC);
    check_val("sub_id", id_log[0], 1);

    // Simultaneous requests held valid: round-robin alternation.
    rsp_log.delete(); id_log.delete();
    set_req(0, 1, 2'd0, 32'd1, 32'd1, 3'd0);
    set_req(1, 1, 2'd0, 32'd2, 32'd2, 3'd0);
    n = 0;
    while (grants.size() < 4 && n < 40) begin
      step(); n++;
      if (acc_id >= 0) grants.push_back(acc_id);
    end
    set_req(0, 0, 2'd0, 32'd0, 32'd0, 3'd0);
    set_req(1, 0, 2'd0, 32'd0, 32'd0, 3'd0);
    drain();
    check_val("rr_count", grants.size(), 4);
    check_val("rr_rsp_count", rsp_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) check_val("rr_grant", grants[i], i % 2);
      if (i < rsp_log.size()) begin
        check_val("rr_data", rsp_log[i], (i % 2) ? 32'd4 : 32'd2);
        check_val("rr_id", id_log[i], i % 2);
      end
    end

    // Backpressure with a reserved opcode; req0 waits.
    rsp_ready = 0;
    set_req(1, 1, 2'd3, 32'd123, 32'd4, 3'd1);
    n = 0;
    do begin step(); n++; end while (acc_id != 1 && n < 6);
    if (acc_id != 1) check_val("bp_accept_timeout", 0, 1);
    set_req(1, 0, 2'd0, 32'd0, 32'd0, 3'd0);
    set_req(0, 1, 2'd0, 32'd7, 32'd8, 3'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("bp_valid", rsp_valid, 1);
      check_val("bp_data", rsp_data, 0);
      check_val("bp_err", rsp_err, 1);
      check_val("bp_req0_ready", req0_ready, 0);
    end
    rsp_ready = 1;
    n = 0;
    do begin step(); n++; end while (acc_id < 0 && n < 6);
    check_val("bp_next_grant", acc_id, 0);
    set_req(0, 0, 2'd0, 32'd0, 32'd0, 3'd0);
    drain();

    // Async reset while the response is held.
    rsp_ready = 0;
    set_req(0, 1, 2'd0, 32'd40, 32'd2, 3'd0);
    n = 0;
    do begin step(); n++; if (acc_id == 0) set_req(0, 0, 2'd0, 32'd0, 32'd0, 3'd0); end
      while (!m_vis && n < 8);
    check_val("pre_reset_valid", rsp_valid, 1);
    rst_n = 0;
    #1;
    check_val("mid_rst_valid", rsp_valid, 0);
    check_val("mid_rst_done", done_count, 0);
    model_reset();
    rsp_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    set_req(0, 1, 2'd0, 32'd3, 32'd4, 3'd0);
    set_req(1, 1, 2'd1, 32'd9, 32'd1, 3'd0);
    step();
    check_val("post_rst_grant", acc_id, 0);
    set_req(0, 0, 2'd0, 32'd0, 32'd0, 3'd0);
    set_req(1, 0, 2'd0, 32'd0, 32'd0, 3'd0);
    drain();
    check_val("post_rst_done", done_count, 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (v[i] && acc_id == i) v[i] = 0;
        else if (v[i] && $urandom_range(9) == 0) v[i] = 0;
        if (!v[i] && $urandom_range(2) == 0) begin
          v[i] = 1;
          op[i] = 2'($urandom_range(3));
          av[i] = $urandom;
          bv[i] = $urandom;
          dv[i] = 3'($urandom_range(7));
        end
      end
      apply();
      rsp_ready = ($urandom_range(3) != 0);
      step();
    end
    v[0] = 0; v[1] = 0; apply();
    rsp_ready = 1;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
